// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo bridge.
// Optional statistics counters are enabled with UART_ECHO_STATS_EN.
package uart_echo_pkg;

   typedef enum logic {
      R_IDLE,
      R_ACK
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_REQ,
      T_BUSY
   } tx_state_t;

   localparam int STAT_W = 16;

   // Saturating add of a small increment to a statistics counter.
   function automatic logic [STAT_W-1:0] sat_add(
      input logic [STAT_W-1:0] a,
      input logic [1:0]        b
   );
      logic [STAT_W:0] s;
      s = {1'b0, a} + {{(STAT_W - 1){1'b0}}, b};
      return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push on full is taken only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [DATA_W-1:0]       din_i,
   output logic [DATA_W-1:0]       dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE  = 1;
   localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == LVL_FULL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered echo bridge from UART receiver to transmitter.
// Define UART_ECHO_STATS_EN to add echo/drop counters.
module uart_echo_fifo
   import uart_echo_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int REQ_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    rx_valid,
   input  logic [DATA_W-1:0]       rx_data,
   output logic                    rx_clear,
   input  logic                    tx_active,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_request,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow,
   output logic                    tx_error,
`ifdef UART_ECHO_STATS_EN
   output logic [STAT_W-1:0]       echo_count,
   output logic [STAT_W-1:0]       drop_count,
`endif
   input  logic                    clr_status
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int TMR_W  = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
   localparam bit TMO_EN = (REQ_TIMEOUT > 0);
   localparam logic [TMR_W-1:0] TMO_LAST =
      TMR_W'(TMO_EN ? REQ_TIMEOUT - 1 : 0);
   localparam logic [TMR_W-1:0] TMR_ONE = 1;

   rx_state_t         rx_state_q;
   tx_state_t         tx_state_q;
   logic              rx_clear_q;
   logic              tx_request_q;
   logic [DATA_W-1:0] tx_data_q;
   logic [TMR_W-1:0]  timer_q;
   logic              overflow_q;
   logic              tx_error_q;

   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic [ADDR_W:0]   fifo_lvl;
   logic              rx_take, tx_take;
   logic              ov_drop, tmo_hit, echo_done;

   assign rx_take   = (rx_state_q == R_IDLE) && rx_valid;
   assign tx_take   = (tx_state_q == T_IDLE) && !fifo_empty && !tx_active;
   assign ov_drop   = rx_take && fifo_full && !tx_take;
   assign tmo_hit   = TMO_EN && (tx_state_q == T_REQ) && !tx_active &&
                      (timer_q == TMO_LAST);
   assign echo_done = (tx_state_q == T_BUSY) && !tx_active;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (rx_take),
      .pop_i   (tx_take),
      .din_i   (rx_data),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_lvl)
   );

   // RX side: capture once per rx_valid level, hold clear until it drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q <= R_IDLE;
         rx_clear_q <= 1'b0;
      end else begin
         unique case (rx_state_q)
            R_IDLE: begin
               if (rx_valid) begin
                  rx_state_q <= R_ACK;
                  rx_clear_q <= 1'b1;
               end
            end
            R_ACK: begin
               if (!rx_valid) begin
                  rx_state_q <= R_IDLE;
                  rx_clear_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // TX side: pop, request, wait for the UART to accept and finish.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q   <= T_IDLE;
         tx_request_q <= 1'b0;
         tx_data_q    <= '0;
         timer_q      <= '0;
      end else begin
         unique case (tx_state_q)
            T_IDLE: begin
               if (tx_take) begin
                  tx_data_q    <= fifo_dout;
                  tx_request_q <= 1'b1;
                  timer_q      <= '0;
                  tx_state_q   <= T_REQ;
               end
            end
            T_REQ: begin
               if (tx_active) begin
                  tx_request_q <= 1'b0;
                  tx_state_q   <= T_BUSY;
               end else if (tmo_hit) begin
                  tx_request_q <= 1'b0;
                  tx_state_q   <= T_IDLE;
               end else if (TMO_EN) begin
                  timer_q <= timer_q + TMR_ONE;
               end
            end
            T_BUSY: begin
               if (!tx_active) tx_state_q <= T_IDLE;
            end
            default: begin
               tx_request_q <= 1'b0;
               tx_state_q   <= T_IDLE;
            end
         endcase
      end
   end

   // Sticky status flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q <= 1'b0;
         tx_error_q <= 1'b0;
      end else begin
         overflow_q <= (overflow_q && !clr_status) || ov_drop;
         tx_error_q <= (tx_error_q && !clr_status) || tmo_hit;
      end
   end

`ifdef UART_ECHO_STATS_EN
   logic [STAT_W-1:0] echo_q;
   logic [STAT_W-1:0] drop_q;
   logic [1:0]        drop_inc;

   assign drop_inc = {1'b0, ov_drop} + {1'b0, tmo_hit};

   // Saturating counters; events in a clear cycle still count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         echo_q <= '0;
         drop_q <= '0;
      end else begin
         echo_q <= sat_add(clr_status ? '0 : echo_q, {1'b0, echo_done});
         drop_q <= sat_add(clr_status ? '0 : drop_q, drop_inc);
      end
   end

   assign echo_count = echo_q;
   assign drop_count = drop_q;
`endif

   assign rx_clear   = rx_clear_q;
   assign tx_request = tx_request_q;
   assign tx_data    = tx_data_q;
   assign fifo_level = fifo_lvl;
   assign overflow   = overflow_q;
   assign tx_error   = tx_error_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo.
// Counter checks are included when UART_ECHO_STATS_EN is defined.
module tb_uart_echo_fifo;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_clear;
   logic       tx_active = 1'b0;
   logic [7:0] tx_data;
   logic       tx_request;
   logic [4:0] fifo_level;
   logic       overflow;
   logic       tx_error;
   logic       clr_status = 1'b0;
`ifdef UART_ECHO_STATS_EN
   logic [15:0] echo_count;
   logic [15:0] drop_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_echo_fifo #(
      .DATA_W      (8),
      .DEPTH       (16),
      .REQ_TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_clear   (rx_clear),
      .tx_active  (tx_active),
      .tx_data    (tx_data),
      .tx_request (tx_request),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .tx_error   (tx_error),
`ifdef UART_ECHO_STATS_EN
      .echo_count (echo_count),
      .drop_count (drop_count),
`endif
      .clr_status (clr_status)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      step();
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
   endtask

   task automatic uart_accept(input string tag, input logic [7:0] exp);
      int n = 0;
      while (!tx_request && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, tx_request, 1);
      chk({tag, "_data"}, tx_data, exp);
      tx_active = 1'b1;
      step();
      chk({tag, "_reqlow"}, tx_request, 0);
      step();
      chk({tag, "_hold"}, tx_data, exp);
      tx_active = 1'b0;
      step();
   endtask

   initial begin
      int cnt;
      // Reset state
      step();
      step();
      chk("rst_rx_clear", rx_clear, 0);
      chk("rst_tx_req", tx_request, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", tx_error, 0);
      reset_n = 1'b1;
      step();

      // 1: single word, latency and clear handshake
      rx_data  = 8'h41;
      rx_valid = 1'b1;
      step();
      chk("t1_clear_n", rx_clear, 1);
      chk("t1_level_n", fifo_level, 1);
      chk("t1_req_n", tx_request, 0);
      step();
      chk("t1_clear_held", rx_clear, 1);
      chk("t1_level_pop", fifo_level, 0);
      chk("t1_req_n2", tx_request, 1);
      rx_valid = 1'b0;
      step();
      chk("t1_clear_low", rx_clear, 0);
      chk("t1_data", tx_data, 8'h41);
      chk("t1_level_nocap", fifo_level, 0);
      tx_active = 1'b1;
      step();
      chk("t1_req_drop", tx_request, 0);
      tx_active = 1'b0;
      step();
      chk("t1_level_end", fifo_level, 0);

      // 2: fill to DEPTH while UART busy, then overflow
      tx_active = 1'b1;
      for (int i = 0; i < 16; i++) send_word(8'h10 + 8'(i));
      chk("t2_level_full", fifo_level, 16);
      chk("t2_ovf_zero", overflow, 0);
      send_word(8'hEE);
      chk("t2_ovf_set", overflow, 1);
      chk("t2_level_keep", fifo_level, 16);
      pulse_clr();
      chk("t2_ovf_clr", overflow, 0);

      // 3: push on full with same-cycle pop is accepted
      rx_data   = 8'hAA;
      rx_valid  = 1'b1;
      tx_active = 1'b0;
      step();
      chk("t3_level", fifo_level, 16);
      chk("t3_ovf", overflow, 0);
      chk("t3_req", tx_request, 1);
      rx_valid = 1'b0;
      for (int i = 0; i < 16; i++) uart_accept("t2_out", 8'h10 + 8'(i));
      uart_accept("t3_out", 8'hAA);
      chk("t3_level_end", fifo_level, 0);
      chk("t3_ovf_end", overflow, 0);

      // 4: request timeout
      send_word(8'h55);
      cnt = 0;
      while (tx_request && cnt < 40) begin
         cnt++;
         step();
      end
      chk("t4_req_cycles", cnt, 8);
      chk("t4_err", tx_error, 1);
      chk("t4_level", fifo_level, 0);
      step();
      step();
      step();
      chk("t4_dropped", tx_request, 0);
      pulse_clr();
      chk("t4_err_clr", tx_error, 0);

      // 5: reset during T_BUSY with queued data
      send_word(8'h61);
      chk("t5_req", tx_request, 1);
      tx_active = 1'b1;
      step();
      send_word(8'h62);
      send_word(8'h63);
      send_word(8'h64);
      chk("t5_level3", fifo_level, 3);
      chk("t5_data", tx_data, 8'h61);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rst_level", fifo_level, 0);
      chk("t5_rst_data", tx_data, 0);
      chk("t5_rst_req", tx_request, 0);
      chk("t5_rst_clear", rx_clear, 0);
      tx_active = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("t5_after_level", fifo_level, 0);
      send_word(8'h71);
      chk("t5b_req", tx_request, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t5b_req_drop", tx_request, 0);
      step();
      reset_n = 1'b1;
      step();

`ifdef UART_ECHO_STATS_EN
      // 6: statistics counters
      chk("t6_echo_rst", echo_count, 0);
      for (int i = 0; i < 3; i++) begin
         send_word(8'h80 + 8'(i));
         uart_accept("t6_out", 8'h80 + 8'(i));
      end
      for (int i = 0; i < 2; i++) begin
         send_word(8'h90);
         cnt = 0;
         while (tx_request && cnt < 40) begin
            cnt++;
            step();
         end
         chk("t6_tmo", tx_request, 0);
      end
      chk("t6_echo", echo_count, 3);
      chk("t6_drop", drop_count, 2);
      pulse_clr();
      chk("t6_echo_clr", echo_count, 0);
      chk("t6_drop_clr", drop_count, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
